// File: rtl/imm_extend_pipe.sv
// Immediate extender with a two-entry (output + skid) registered handshake stage.
// Optional fire counter on out_cnt is built when IMM_EXT_CNT_EN is defined.
module imm_extend_pipe #(
  parameter int HALF_W = 4,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] in_hi,
  input  logic [HALF_W-1:0] in_lo,
  input  logic [1:0]        in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
`ifdef IMM_EXT_CNT_EN
  input  logic              out_ready,
  output logic [15:0]       out_cnt
`else
  input  logic              out_ready
`endif
);

  localparam int IN_W  = 2 * HALF_W;
  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             fire;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;
  logic [IN_W-1:0]  raw;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] skid_q;

  assign raw    = {in_hi, in_lo};
  assign sext   = {{PAD_W{raw[IN_W-1]}}, raw};
  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ext = sext;
    case (in_mode)
      2'b00:   ext = sext;
      2'b01:   ext = {{PAD_W{1'b0}}, raw};
      2'b10:   ext = {raw, {PAD_W{1'b0}}};
      default: ext = {sext[OUT_W-2:0], 1'b0};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = BUSY;
      BUSY: begin
        if (accept && !fire)      state_next = FULL;
        else if (!accept && fire) state_next = EMPTY;
      end
      FULL:    if (fire) state_next = BUSY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state != FULL);
    out_valid = (state != EMPTY);
  end

  // Register load enables; accept & fire in BUSY refills the output register directly.
  always_comb begin
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: load_out = accept;
      BUSY: begin
        load_out  = accept & fire;
        load_skid = accept & ~fire;
      end
      FULL: begin
        load_out      = fire;
        out_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: data registers are reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : ext;
      if (load_skid) skid_q <= ext;
    end
  end

  assign out_data = out_q;

`ifdef IMM_EXT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       out_cnt <= '0;
    else if (fire) out_cnt <= out_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL provide parameter HALF_W, default 4: width of each immediate half-field.
REQ-002 SHALL provide parameter OUT_W, default 16: width of the extended result; legal range OUT_W >= 2*HALF_W+1.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port in_hi  input  HALF_W  upper half of the raw immediate.
REQ-006 SHALL provide port in_lo  input  HALF_W  lower half of the raw immediate.
REQ-007 SHALL provide port in_mode  input  2  extension mode, captured together with the data.
REQ-008 SHALL provide port in_valid  input  1  producer offers {in_hi,in_lo,in_mode}.
REQ-009 SHALL provide port in_ready  output  1  block can accept; accept = in_valid & in_ready at the clock edge.
REQ-010 SHALL provide port out_data  output  OUT_W  extended immediate.
REQ-011 SHALL provide port out_valid  output  1  out_data is valid.
REQ-012 SHALL provide port out_ready  input  1  consumer takes out_data; fire = out_valid & out_ready.

Function
REQ-013 SHALL form raw value a = {in_hi,in_lo}, width IN_W = 2*HALF_W.
REQ-014 SHALL compute per mode: 00 sign-extend a to OUT_W; 01 zero-extend a; 10 load-upper, i.e. a in bits [OUT_W-1:OUT_W-IN_W] with zeros below; 11 sign-extend a, then shift left by 1 (branch offset), zero fill at bit 0.
REQ-015 SHALL compute the result at accept time and store it registered; out_data SHALL be driven only from registers.
REQ-016 SHALL hold two storage entries (output register, skid register) controlled by a 3-state FSM: EMPTY, BUSY, FULL.
REQ-017 In EMPTY, SHALL go to BUSY on accept and load the output register; otherwise SHALL stay.
REQ-018 In BUSY: accept & fire -> BUSY, output register loads the new value; accept & !fire -> FULL, skid loads; !accept & fire -> EMPTY; neither -> stay.
REQ-019 In FULL, fire -> BUSY with the output register loaded from skid; otherwise SHALL stay.
REQ-020 SHALL drive in_ready = 1 in EMPTY and BUSY, 0 in FULL, and 0 while rst is high.
REQ-021 SHALL drive out_valid = 1 in BUSY and FULL, 0 in EMPTY.
REQ-022 Latency: accept at edge N SHALL give out_valid = 1 with the result after edge N (1 cycle).
REQ-023 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-024 While out_valid & !out_ready, out_data SHALL stay stable.
REQ-025 Results SHALL leave in acceptance order; nothing SHALL be dropped or duplicated.
REQ-026 A simultaneous accept and fire in BUSY SHALL not pass through FULL.

Reset
REQ-027 rst high at an edge SHALL force state to EMPTY, out_valid = 0, out_data = 0, and skid = 0.
REQ-028 Reset SHALL override any simultaneous accept or fire; in-flight entries SHALL be discarded.
REQ-029 in_ready SHALL return to 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro IMM_EXT_CNT_EN defined: SHALL add output port out_cnt, 16 bits, counting fire events, wrapping from 16'hFFFF to 0, and reset to 0.
REQ-031 Macro IMM_EXT_CNT_EN undefined: port out_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification (HALF_W=4, OUT_W=16)
REQ-032 Mode 00 with in_hi=F, in_lo=6: accept -> out_data=16'hFFF6 one cycle later, out_valid=1.
REQ-033 Modes 01, 10 and 11 with in_hi=F, in_lo=6 -> 16'h00F6, 16'hF600 and 16'hFFEC respectively; mode 00 with hi=7, lo=F -> 16'h007F.
REQ-034 Backpressure: out_ready=0, offer 3 beats (0x01, 0x02, 0x03, mode 01) -> first two accepted, in_ready=0 after the second, third held. Then out_ready=1 -> outputs 0x0001, 0x0002, 0x0003 in order.
REQ-035 Streaming: out_ready=1 and in_valid=1 for 8 cycles -> 8 consecutive results with no bubbles; FSM never enters FULL.
REQ-036 Reset mid-operation: rst in FULL -> next cycle out_valid=0, out_data=0, in_ready=1 after release, out_cnt=0 (when enabled).
REQ-037 With IMM_EXT_CNT_EN: 65537 fires -> out_cnt=1 (wrap checked).
